i2c_scl_gen: RTL and testbench

- Parametrised I2C bit-clock generator clocked from CLOCK_50; replaces the fixed three-rate SCL divider.
- Produces a registered open-drain-style SCL level plus single-cycle phase strobes (fall, data-change, rise, sample) for the I2C master FSM.
- Adds a runtime-programmable rate, glitch-free rate changes at period boundaries, clock-stretch detection and a clean stop with SCL released high.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_sync2.sv | 30 +++
 rtl/i2c_scl_gen.sv | 188 ++++++++++++++++++
 tb/tb_i2c_scl_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C master blocks.
//   - state_t   : SCL generator phase encoding (IDLE = 0)
//   - SL_*      : rate-select codes for the sl input
//   - DIV_*_50M : default quarter-period dividers for a 50 MHz clock
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW0  = 3'd1,
        LOW1  = 3'd2,
        HIGH0 = 3'd3,
        HIGH1 = 3'd4
    } state_t;

    localparam logic [1:0] SL_STD   = 2'b00;
    localparam logic [1:0] SL_FAST  = 2'b01;
    localparam logic [1:0] SL_FASTP = 2'b10;
    localparam logic [1:0] SL_CFG   = 2'b11;

    localparam int DIV_STD_50M   = 125;  // 100 kHz
    localparam int DIV_FAST_50M  = 31;   // ~400 kHz
    localparam int DIV_FASTP_50M = 12;   // ~1 MHz
    localparam int DIV_MIN_DEF   = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// i2c_sync2: two-flop synchroniser for an asynchronous input.
//   CLOCK_50 : clock
//   rst      : asynchronous active-high reset, both flops load RST_VAL
//   d        : asynchronous input
//   q        : synchronised output (2-cycle latency)
module i2c_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: programmable I2C bit-clock generator.
//   CLOCK_50    : system clock
//   rst         : asynchronous active-high reset
//   en          : run request (sampled in IDLE and at the end of each period)
//   sl          : rate select (00/01/10 fixed dividers, 11 = div_cfg)
//   div_cfg     : runtime quarter-period for sl = 11
//   scl_in      : sensed SCL line (asynchronous)
//   scl_out     : SCL drive level, 1 = release
//   tick_fall / tick_data / tick_rise / tick_sample : 1-cycle phase strobes
//   stretching  : slave is holding SCL low during the high phase
//   busy        : generator is not idle
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DIV_SL0 = DIV_STD_50M,
    parameter int DIV_SL1 = DIV_FAST_50M,
    parameter int DIV_SL2 = DIV_FASTP_50M,
    parameter int DIV_MIN = DIV_MIN_DEF
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sl,
    input  logic [CNT_W-1:0] div_cfg,
    input  logic             scl_in,
    output logic             scl_out,
    output logic             tick_fall,
    output logic             tick_data,
    output logic             tick_rise,
    output logic             tick_sample,
    output logic             stretching,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DIV0_W    = CNT_W'(DIV_SL0);
    localparam logic [CNT_W-1:0] DIV1_W    = CNT_W'(DIV_SL1);
    localparam logic [CNT_W-1:0] DIV2_W    = CNT_W'(DIV_SL2);
    localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] DIV_RST_W = CNT_W'(max_int(DIV_SL0, DIV_MIN));

    logic             scl_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] q_q, q_d;
    logic [CNT_W-1:0] div_lat_q, div_lat_d;
    logic             scl_out_q, scl_out_d;
    logic             tick_fall_q, tick_fall_d;
    logic             tick_data_q, tick_data_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_sample_q, tick_sample_d;
    logic             stretching_q, stretching_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] div_cand;
    logic [CNT_W-1:0] div_sel;
    logic             terminal;

    i2c_sync2 #(
        .RST_VAL (1'b1)
    ) u_scl_sync (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .d        (scl_in),
        .q        (scl_s)
    );

    // Divider candidate, floored at DIV_MIN; only sampled on entry to LOW0.
    always_comb begin
        div_cand = DIV0_W;
        case (sl)
            SL_STD:   div_cand = DIV0_W;
            SL_FAST:  div_cand = DIV1_W;
            SL_FASTP: div_cand = DIV2_W;
            SL_CFG:   div_cand = div_cfg;
            default:  div_cand = DIV0_W;
        endcase
        div_sel = (div_cand < DIV_MIN_W) ? DIV_MIN_W : div_cand;
    end

    assign terminal = (q_q == div_lat_q - 1'b1);

    always_comb begin
        state_d       = state_q;
        q_d           = q_q + 1'b1;
        div_lat_d     = div_lat_q;
        scl_out_d     = scl_out_q;
        tick_fall_d   = 1'b0;
        tick_data_d   = 1'b0;
        tick_rise_d   = 1'b0;
        tick_sample_d = 1'b0;
        stretching_d  = 1'b0;

        case (state_q)
            IDLE: begin
                q_d       = '0;
                scl_out_d = 1'b1;
                if (en) begin
                    state_d     = LOW0;
                    div_lat_d   = div_sel;
                    scl_out_d   = 1'b0;
                    tick_fall_d = 1'b1;
                end
            end
            LOW0: begin
                if (terminal) begin
                    state_d     = LOW1;
                    q_d         = '0;
                    tick_data_d = 1'b1;
                end
            end
            LOW1: begin
                if (terminal) begin
                    state_d     = HIGH0;
                    q_d         = '0;
                    scl_out_d   = 1'b1;
                    tick_rise_d = 1'b1;
                end
            end
            HIGH0: begin
                // The counter freezes while the sensed line is low; this also
                // covers the synchroniser lag right after release.
                if (!scl_s) begin
                    q_d          = q_q;
                    stretching_d = 1'b1;
                end else if (terminal) begin
                    state_d       = HIGH1;
                    q_d           = '0;
                    tick_sample_d = 1'b1;
                end
            end
            HIGH1: begin
                if (terminal) begin
                    q_d = '0;
                    if (en) begin
                        state_d     = LOW0;
                        div_lat_d   = div_sel;
                        scl_out_d   = 1'b0;
                        tick_fall_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        scl_out_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                q_d       = '0;
                scl_out_d = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            q_q           <= '0;
            div_lat_q     <= DIV_RST_W;
            scl_out_q     <= 1'b1;
            tick_fall_q   <= 1'b0;
            tick_data_q   <= 1'b0;
            tick_rise_q   <= 1'b0;
            tick_sample_q <= 1'b0;
            stretching_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_q           <= q_d;
            div_lat_q     <= div_lat_d;
            scl_out_q     <= scl_out_d;
            tick_fall_q   <= tick_fall_d;
            tick_data_q   <= tick_data_d;
            tick_rise_q   <= tick_rise_d;
            tick_sample_q <= tick_sample_d;
            stretching_q  <= stretching_d;
            busy_q        <= busy_d;
        end
    end

    assign scl_out     = scl_out_q;
    assign tick_fall   = tick_fall_q;
    assign tick_data   = tick_data_q;
    assign tick_rise   = tick_rise_q;
    assign tick_sample = tick_sample_q;
    assign stretching  = stretching_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: directed self-checking bench for i2c_scl_gen.
// Outputs are sampled on the falling edge; inputs also change there.
module tb_i2c_scl_gen;

    localparam int CNT_W = 16;
    localparam int T_FALL = 0, T_DATA = 1, T_RISE = 2, T_SAMPLE = 3;

    logic             CLOCK_50 = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [1:0]       sl = 2'b00;
    logic [CNT_W-1:0] div_cfg = '0;
    logic             scl_in = 1'b1;
    logic             scl_out;
    logic             tick_fall, tick_data, tick_rise, tick_sample;
    logic             stretching, busy;

    int checks = 0;
    int passes = 0;
    int overlap = 0;

    i2c_scl_gen dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .en          (en),
        .sl          (sl),
        .div_cfg     (div_cfg),
        .scl_in      (scl_in),
        .scl_out     (scl_out),
        .tick_fall   (tick_fall),
        .tick_data   (tick_data),
        .tick_rise   (tick_rise),
        .tick_sample (tick_sample),
        .stretching  (stretching),
        .busy        (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Strobes must never overlap.
    always @(negedge CLOCK_50) begin
        if ((32'(tick_fall) + 32'(tick_data) + 32'(tick_rise) + 32'(tick_sample)) > 1)
            overlap++;
    end

    function automatic logic cur_tick(input int sel);
        case (sel)
            T_FALL:   return tick_fall;
            T_DATA:   return tick_data;
            T_RISE:   return tick_rise;
            default:  return tick_sample;
        endcase
    endfunction

    function automatic logic any_tick();
        return tick_fall | tick_data | tick_rise | tick_sample;
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $display("check %-16s observed %0d expected %0d", tag, obs, exp);
    endtask

    // Step at least once, until the selected strobe is seen or the budget runs out.
    task automatic wait_tick(input int sel, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!cur_tick(sel) && n < budget);
    endtask

    task automatic expect_gap(input string tag, input int sel, input int exp);
        int n;
        wait_tick(sel, 200, n);
        check(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        int bad;
        int sc;
        int st;

        // Reset state
        step();
        step();
        check("rst_scl_out", 32'(scl_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ticks", 32'(any_tick()), 32'd0);
        check("rst_stretch", 32'(stretching), 32'd0);
        rst = 1'b0;

        // Idle with en=0: nothing happens for 1000 cycles
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (any_tick() || !scl_out || busy) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // sl=10: divider 12, period 48
        sl = 2'b10;
        en = 1'b1;
        expect_gap("first_fall", T_FALL, 1);
        check("fall_scl_low", 32'(scl_out), 32'd0);
        check("fall_busy", 32'(busy), 32'd1);
        expect_gap("sl2_data", T_DATA, 12);
        check("data_scl_low", 32'(scl_out), 32'd0);
        expect_gap("sl2_rise", T_RISE, 12);
        check("rise_scl_high", 32'(scl_out), 32'd1);
        expect_gap("sl2_sample", T_SAMPLE, 12);
        check("sample_scl_high", 32'(scl_out), 32'd1);
        expect_gap("sl2_fall", T_FALL, 12);

        // sl=11, div_cfg=0 mid-period: current period stays 12, next clamps to 2
        sl = 2'b11;
        div_cfg = 16'd0;
        expect_gap("cfg_keep_data", T_DATA, 12);
        expect_gap("cfg_keep_rise", T_RISE, 12);
        expect_gap("cfg_keep_sample", T_SAMPLE, 12);
        expect_gap("cfg_keep_fall", T_FALL, 12);
        expect_gap("clamp0_data", T_DATA, 2);
        expect_gap("clamp0_rise", T_RISE, 2);
        expect_gap("clamp0_sample", T_SAMPLE, 2);
        div_cfg = 16'd1;
        expect_gap("clamp0_fall", T_FALL, 2);
        expect_gap("clamp1_data", T_DATA, 2);
        div_cfg = 16'd5;  // changed mid-LOW1
        expect_gap("clamp1_rise", T_RISE, 2);
        expect_gap("clamp1_sample", T_SAMPLE, 2);
        expect_gap("clamp1_fall", T_FALL, 2);
        expect_gap("cfg5_data", T_DATA, 5);
        expect_gap("cfg5_rise", T_RISE, 5);
        expect_gap("cfg5_sample", T_SAMPLE, 5);
        sl = 2'b10;
        expect_gap("cfg5_fall", T_FALL, 5);

        // Clock stretch: slave holds SCL low for 30 cycles after tick_rise
        expect_gap("str_data", T_DATA, 12);
        expect_gap("str_rise", T_RISE, 12);
        scl_in = 1'b0;
        sc = 0;
        st = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i >= 3 && stretching) sc++;
            if (any_tick()) st++;
        end
        check("stretch_cycles", 32'(sc), 32'd28);
        check("stretch_no_tick", 32'(st), 32'd0);
        scl_in = 1'b1;
        expect_gap("str_sample", T_SAMPLE, 12);
        check("str_end", 32'(stretching), 32'd0);

        // en dropped during LOW0: the period completes then stops high
        expect_gap("stop_fall", T_FALL, 12);
        en = 1'b0;
        expect_gap("stop_data", T_DATA, 12);
        expect_gap("stop_rise", T_RISE, 12);
        expect_gap("stop_sample", T_SAMPLE, 12);
        for (int i = 0; i < 11; i++) step();
        check("stop_busy_last", 32'(busy), 32'd1);
        step();
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_scl_high", 32'(scl_out), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (any_tick() || busy) bad++;
        end
        check("stop_quiet", 32'(bad), 32'd0);

        // rst pulsed during HIGH0 with en held
        en = 1'b1;
        expect_gap("rr_fall", T_FALL, 1);
        expect_gap("rr_data", T_DATA, 12);
        expect_gap("rr_rise", T_RISE, 12);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check("rr_scl_out", 32'(scl_out), 32'd1);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_ticks", 32'(any_tick()), 32'd0);
        step();
        step();
        rst = 1'b0;
        expect_gap("rr_restart", T_FALL, 1);
        check("rr_restart_scl", 32'(scl_out), 32'd0);

        check("strobe_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
